// File: rtl/tristate_bus_receiver.sv
// -----------------------------------------------------------------------------
// tristate_bus_receiver
//
// Receiving end of a shared N-bit tri-state data bus. Every rising clk edge
// with bus_en=1 samples bus_in into a small show-ahead FIFO. Local logic
// drains the FIFO through a valid/ready handshake. When the FIFO is full,
// bus_hold tells the driver to stop. Words that arrive while the FIFO is full
// are dropped and counted.
//
// Optional feature (compile-time macro TRISTATE_RX_ZCHECK_EN):
//   When this macro is defined, an enabled word with any X or Z bit is
//   discarded and counted in zerr_cnt. When it is undefined, every enabled
//   word is pushed unchecked and zerr_cnt is tied to 0.
//
// Parameters:
//   N      bus / data width in bits
//   DEPTH  FIFO depth in words (power of two, >= 2)
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   rst_n     in   asynchronous active-low reset
//   bus_in    in   N   shared tri-state bus
//   bus_en    in   1   driver enable; 1 = bus driven this cycle
//   bus_hold  out  1   back-pressure to the driver; 1 = FIFO full
//   rd_data   out  N   head-of-FIFO word (show-ahead)
//   rd_valid  out  1   rd_data holds a valid word
//   rd_ready  in   1   consumer accepts rd_data this cycle
//   level     out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   ovf_cnt   out  8   words dropped on full, saturating at 255
//   zerr_cnt  out  8   words discarded for X/Z content, saturating at 255
// -----------------------------------------------------------------------------
module tristate_bus_receiver #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           bus_in,
  input  logic                   bus_en,
  output logic                   bus_hold,
  output logic [N-1:0]           rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_cnt,
  output logic [7:0]             zerr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    CNT_MAX  = 8'hFF;

  // Storage is not reset; reset clears only the pointers and the occupancy.
  logic [N-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic [7:0]    ovf_cnt_r;

  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          ovf_s;
  logic          zbad_s;

`ifdef TRISTATE_RX_ZCHECK_EN
  logic [7:0]    zerr_cnt_r;

  // Any X or Z bit poisons the reduction-XOR, which then compares equal to X.
  function automatic logic has_xz(input logic [N-1:0] word);
    has_xz = ((^word) === 1'bx);
  endfunction
`endif

  // Classify this cycle: pop, push, overflow drop, or X/Z discard.
  always_comb begin
    full_s = (level_r == LVL_FULL);
    pop_s  = (level_r != LVL_ZERO) && rd_ready;
`ifdef TRISTATE_RX_ZCHECK_EN
    zbad_s = bus_en && has_xz(bus_in);
`else
    zbad_s = 1'b0;
`endif
    push_s = 1'b0;
    ovf_s  = 1'b0;
    if (bus_en && !zbad_s) begin
      // A pop in the same cycle frees a slot, even when the FIFO is full.
      if (!full_s || pop_s) begin
        push_s = 1'b1;
        ovf_s  = 1'b0;
      end else begin
        push_s = 1'b0;
        ovf_s  = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      ovf_s  = 1'b0;
    end
  end

  // Compute the next occupancy from the push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Write accepted words into the storage array.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus_in;
    end
  end

  // Update the pointers, the occupancy and the overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= LVL_ZERO;
      ovf_cnt_r <= 8'd0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      if (ovf_s && (ovf_cnt_r != CNT_MAX)) begin
        ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end
    end
  end

`ifdef TRISTATE_RX_ZCHECK_EN
  // Count discarded X/Z words, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zerr_cnt_r <= 8'd0;
    end else if (zbad_s && (zerr_cnt_r != CNT_MAX)) begin
      zerr_cnt_r <= zerr_cnt_r + 8'd1;
    end
  end

  assign zerr_cnt = zerr_cnt_r;
`else
  assign zerr_cnt = 8'd0;
`endif

  // The outputs depend on registered state only.
  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = (level_r != LVL_ZERO);
  assign bus_hold = full_s;
  assign level    = level_r;
  assign ovf_cnt  = ovf_cnt_r;

endmodule

// File: tb/tb_tristate_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_receiver
//
// Self-checking bench for tristate_bus_receiver (N=4, DEPTH=4). Each word the
// receiver should accept is pushed to a scoreboard queue. Each time a word is
// popped, the value taken from the front of the queue is compared with rd_data.
// -----------------------------------------------------------------------------
module tb_tristate_bus_receiver;

  logic       clk;
  logic       rst_n;
  logic [3:0] bus_in;
  logic       bus_en;
  logic       bus_hold;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] level;
  logic [7:0] ovf_cnt;
  logic [7:0] zerr_cnt;

  int         total;
  int         bad;
  logic [3:0] exp_q[$];
  logic [3:0] want;

  tristate_bus_receiver #(.N(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_in   (bus_in),
    .bus_en   (bus_en),
    .bus_hold (bus_hold),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .level    (level),
    .ovf_cnt  (ovf_cnt),
    .zerr_cnt (zerr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, then land 1 time unit after the edge.
  task automatic drive(input logic en, input logic [3:0] d, input logic rdy);
    bus_en   = en;
    bus_in   = d;
    rd_ready = rdy;
    @(posedge clk);
    #1;
    bus_en   = 1'b0;
    bus_in   = 4'bzzzz;
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus_en = 1'b0; bus_in = 4'bzzzz; rd_ready = 1'b0;
    #2;
    total++; if (level !== 3'd0)    begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    total++; if (bus_hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", bus_hold); end
    total++; if (ovf_cnt !== 8'd0)  begin bad++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
    total++; if (zerr_cnt !== 8'd0) begin bad++; $display("FAIL reset_zerr: got %0d want 0", zerr_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    drive(1'b1, 4'b0101, 1'b0);
    exp_q.push_back(4'b0101);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rd_valid); end
    total++; if (rd_data !== exp_q[0]) begin bad++; $display("FAIL basic_data: got %h want %h", rd_data, exp_q[0]); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL basic_level: got %0d want 1", level); end
    void'(exp_q.pop_front());
    drive(1'b0, 4'b0000, 1'b1);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid: got %b want 0", rd_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL basic_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      exp_q.push_back(4'(i));
      if (i < 4) begin
        total++; if (bus_hold !== 1'b0) begin bad++; $display("FAIL fill_hold_early %0d: got %b want 0", i, bus_hold); end
      end
    end
    total++; if (bus_hold !== 1'b1) begin bad++; $display("FAIL fill_hold: got %b want 1", bus_hold); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level: got %0d want 4", level); end
    drive(1'b1, 4'hE, 1'b0);
    drive(1'b1, 4'hE, 1'b0);
    total++; if (ovf_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt: got %0d want 2", ovf_cnt); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== want) begin bad++; $display("FAIL fill_drain: got %b/%h want 1/%h", rd_valid, rd_data, want); end
      drive(1'b0, 4'h0, 1'b1);
    end
    total++; if (level !== 3'd0 || bus_hold !== 1'b0) begin bad++; $display("FAIL fill_empty: got level %0d hold %b want 0/0", level, bus_hold); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      exp_q.push_back(4'(i));
    end
    want = exp_q.pop_front();
    total++; if (rd_data !== want) begin bad++; $display("FAIL fullpp_head: got %h want %h", rd_data, want); end
    drive(1'b1, 4'hF, 1'b1);
    exp_q.push_back(4'hF);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fullpp_level: got %0d want 4", level); end
    total++; if (ovf_cnt !== 8'd2) begin bad++; $display("FAIL fullpp_ovf: got %0d want 2", ovf_cnt); end
    total++; if (bus_hold !== 1'b1) begin bad++; $display("FAIL fullpp_hold: got %b want 1", bus_hold); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== want) begin bad++; $display("FAIL fullpp_drain: got %b/%h want 1/%h", rd_valid, rd_data, want); end
      drive(1'b0, 4'h0, 1'b1);
      if (exp_q.size() == 3) begin
        total++; if (bus_hold !== 1'b0) begin bad++; $display("FAIL fullpp_hold_fall: got %b want 0", bus_hold); end
      end
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      exp_q.push_back(4'(i));
      want = exp_q.pop_front();
      total++; if (level !== 3'd1 || rd_data !== want) begin bad++; $display("FAIL wrap %0d: got level %0d data %h want 1/%h", i, level, rd_data, want); end
      drive(1'b0, 4'h0, 1'b1);
      total++; if (level !== 3'd0) begin bad++; $display("FAIL wrap_pop %0d: got %0d want 0", i, level); end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 4'hA, 1'b0);
    exp_q.push_back(4'hA);
    for (int i = 0; i < 8; i++) begin
      want = exp_q.pop_front();
      total++; if (rd_data !== want) begin bad++; $display("FAIL b2b_data %0d: got %h want %h", i, rd_data, want); end
      drive(1'b1, 4'(i + 3), 1'b1);
      exp_q.push_back(4'(i + 3));
      total++; if (level !== 3'd1) begin bad++; $display("FAIL b2b_level %0d: got %0d want 1", i, level); end
    end
    want = exp_q.pop_front();
    total++; if (rd_data !== want) begin bad++; $display("FAIL b2b_last: got %h want %h", rd_data, want); end
    drive(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'(i + 7), 1'b0);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL arst_pre_level: got %0d want 3", level); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++; if (level !== 3'd0)    begin bad++; $display("FAIL arst_level: got %0d want 0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", rd_valid); end
    total++; if (bus_hold !== 1'b0) begin bad++; $display("FAIL arst_hold: got %b want 0", bus_hold); end
    total++; if (ovf_cnt !== 8'd0)  begin bad++; $display("FAIL arst_ovf: got %0d want 0", ovf_cnt); end
    #1 rst_n = 1'b1;
    drive(1'b1, 4'b1110, 1'b0);
    exp_q.push_back(4'b1110);
    want = exp_q.pop_front();
    total++; if (rd_data !== want || level !== 3'd1) begin bad++; $display("FAIL arst_push: got %h level %0d want %h/1", rd_data, level, want); end
    drive(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_ovf_saturate;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i + 9), 1'b0);
      exp_q.push_back(4'(i + 9));
    end
    for (int i = 0; i < 260; i++) drive(1'b1, 4'h5, 1'b0);
    total++; if (ovf_cnt !== 8'd255) begin bad++; $display("FAIL ovf_sat: got %0d want 255", ovf_cnt); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_sat_level: got %0d want 4", level); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++; if (rd_data !== want) begin bad++; $display("FAIL ovf_sat_drain: got %h want %h", rd_data, want); end
      drive(1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_zcheck;
    drive(1'b1, 4'bzzzz, 1'b0);
    drive(1'b1, 4'b1x11, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
`ifdef TRISTATE_RX_ZCHECK_EN
    total++; if (zerr_cnt !== 8'd2) begin bad++; $display("FAIL zchk_cnt: got %0d want 2", zerr_cnt); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL zchk_level: got %0d want 1", level); end
`else
    total++; if (zerr_cnt !== 8'd0) begin bad++; $display("FAIL zchk_cnt: got %0d want 0", zerr_cnt); end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL zchk_level: got %0d want 3", level); end
    // The first two words carry undefined content, so only pop them.
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
`endif
    exp_q.push_back(4'b1111);
    want = exp_q.pop_front();
    total++; if (rd_data !== want || rd_valid !== 1'b1) begin bad++; $display("FAIL zchk_data: got %h/%b want %h/1", rd_data, rd_valid, want); end
    drive(1'b0, 4'h0, 1'b1);
    total++; if (ovf_cnt !== 8'd255) begin bad++; $display("FAIL zchk_ovf: got %0d want 255", ovf_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_ovf_saturate();
    test_zcheck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tristate_bus_receiver.md
# tristate_bus_receiver

Receiving end of the shared N-bit tri-state data bus driven by the team's tri-state buffers. Samples the bus on every clock edge where the driver's enable is high, queues the words in a small FIFO, and presents them to local logic through a valid/ready handshake. Asserts back-pressure to the driver when full and counts dropped words.

## Interface
- N, default 4: bus and data width in bits.
- DEPTH, default 4: FIFO depth in words, power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- bus_in  input  N  shared tri-state bus wire (driver output when enabled, Z otherwise).
- bus_en  input  1  driver enable, the same signal that controls the driving buffer; 1 = bus driven this cycle.
- bus_hold  output  1  back-pressure to the driver; 1 = FIFO full.
- rd_data  output  N  head-of-FIFO word (show-ahead).
- rd_valid  output  1  rd_data holds a valid word.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- ovf_cnt  output  8  words dropped because the FIFO was full, saturating.
- zerr_cnt  output  8  words discarded for X/Z content, saturating; tied 0 when the feature is compiled out.

## Operation
- Push: at a rising clk edge with bus_en=1, bus_in is written at the write pointer if a slot is free.
- Pop: at a rising clk edge with rd_valid=1 and rd_ready=1, the read pointer advances.
- Pointers wrap modulo DEPTH; level tracks occupancy. Full: level==DEPTH. Empty: level==0.
- Push and pop in the same cycle: both happen and level is unchanged. This includes the full case: the pop frees the slot and the push is accepted, with no overflow counted.
- Push while full without a pop: the word is dropped, ovf_cnt increments, and it saturates at 255.
- rd_ready while empty: no effect.
- bus_en=0: bus_in is ignored entirely, whether it is Z or driven.
- rd_data shows the head word whenever rd_valid=1. Its value is don't-care when empty.
- Outputs are combinational from registered state only: rd_valid=(level!=0), bus_hold=(level==DEPTH), and rd_data is the FIFO head. bus_in, bus_en and rd_ready never reach any output combinationally.

## Timing
- Reset (rst_n=0, effective immediately with no clock needed):
  - level=0, rd_valid=0, bus_hold=0, ovf_cnt=0, zerr_cnt=0.
  - Pointers are 0 and rd_data is don't-care.
  - FIFO contents are not cleared.
- Reset deasserting mid-stream: all queued words are lost. The first edge after release with bus_en=1 pushes normally.
- Latency: a word pushed at edge k appears on rd_data with rd_valid=1 after edge k if the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- bus_hold rises after the edge that makes level==DEPTH and falls after the edge that pops from full without a push.
- The driver must sample bus_hold before driving. Words driven while bus_hold=1 are dropped and counted.

## Configuration
- TRISTATE_RX_ZCHECK_EN defined:
  - A word pushed with any bit X or Z (reduction-XOR compared with case equality to 1'bx) is discarded.
  - zerr_cnt increments, saturating at 255.
  - level, pointers and ovf_cnt are unaffected.
  - A discarded word never counts as overflow, even when the FIFO is full.
- TRISTATE_RX_ZCHECK_EN undefined:
  - Every enabled word is pushed unchecked.
  - zerr_cnt is constant 0.
  - The logic is synthesizable.

## Test plan
1. Reset, basic path. Release rst_n. One cycle with bus_en=1 and bus_in=4'b0101, with rd_ready=0. Required:
   - After the edge: rd_valid=1, rd_data=4'b0101, level=1.
   - Then rd_ready=1 for one cycle: rd_valid=0, level=0.
2. Fill and overflow. Push 4'h1, 4'h2, 4'h3, 4'h4 back-to-back with rd_ready=0; the bus_hold check applies after the fourth push. Then push 4'hE twice more. Required:
   - After the fourth push: bus_hold=1, level=4.
   - After the two extra pushes: ovf_cnt=2 and level=4.
   - Draining returns 1,2,3,4 in order.
3. Simultaneous push and pop at full. Start with the FIFO holding 1,2,3,4. Assert bus_en=1 with bus_in=4'hF and rd_ready=1 on the same cycle. Required:
   - level=4, ovf_cnt unchanged.
   - Draining returns 2,3,4,F.
4. Wrap-around. Run 10 push-then-pop pairs with values 0..9. Required:
   - Every pop returns the matching value.
   - level never exceeds 1 and pointers wrap cleanly.
5. Asynchronous reset mid-operation. With level=3, pulse rst_n low between clock edges. Required:
   - Immediately: level=0, rd_valid=0, bus_hold=0, ovf_cnt=0.
   - The next push of 4'b1110 reads back as 4'b1110.
6. Z-check, with TRISTATE_RX_ZCHECK_EN defined. Drive bus_in=4'bzzzz and then 4'b1x11 with bus_en=1, then 4'b1111. Required:
   - zerr_cnt=2, level=1, rd_data=4'b1111.
   - Without the macro, the same stimulus gives level=3 and zerr_cnt=0.
